// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = WIDTH / BLOCK;

  // Group generate/propagate from one block of bit-level g/p, returned as {G, P}.
  function automatic logic [1:0] grp_gp(input logic [BLOCK-1:0] gb, input logic [BLOCK-1:0] pb);
    logic gv;
    logic pv;
    gv = 1'b0;
    pv = 1'b1;
    for (int i = 32'sd0; i < BLOCK; i++) begin
      gv = gb[i] | (pb[i] & gv);
      pv = pv & pb[i];
    end
    return {gv, pv};
  endfunction

  // Second-level lookahead: each group carry is a flat sum of products over lower groups.
  function automatic logic [NG:0] grp_carry(input logic [NG-1:0] gg, input logic [NG-1:0] gp,
                                            input logic c0);
    logic [NG:0] c;
    logic        t;
    c    = {(NG+1){1'b0}};
    c[0] = c0;
    for (int k = 32'sd1; k <= NG; k++) begin
      t = c0;
      for (int j = 32'sd0; j < k; j++) t = t & gp[j];
      c[k] = t;
      for (int j = 32'sd0; j < k; j++) begin
        t = gg[j];
        for (int m = j + 32'sd1; m < k; m++) t = t & gp[m];
        c[k] = c[k] | t;
      end
    end
    return c;
  endfunction

  // Carry into every bit, restarting each block from its lookahead group carry.
  function automatic logic [WIDTH-1:0] bit_carry(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p,
                                                 input logic [NG:0] cg);
    logic [WIDTH-1:0] c;
    logic             cc;
    c  = {WIDTH{1'b0}};
    cc = 1'b0;
    for (int i = 32'sd0; i < WIDTH; i++) begin
      if ((i % BLOCK) == 32'sd0) begin
        cc = cg[i / BLOCK];
      end else begin
        cc = cc;
      end
      c[i] = cc;
      cc   = g[i] | (p[i] & cc);
    end
    return c;
  endfunction

  logic [WIDTH-1:0] b_eff_s, g_s, p_s, x_s;
  logic [NG-1:0]    gg_s, gp_s;
  logic             r1_s, r2_s;
  logic [NG:0]      cg_s;
  logic [WIDTH-1:0] carry_s, sum_s;

  logic             v1_r, c0_r, v2_r, cout_r;
  logic [WIDTH-1:0] g_r, p_r, x_r, y_r;
  logic [NG-1:0]    gg_r, gp_r;

  assign r2_s      = !v2_r || out_ready;
  assign r1_s      = !v1_r || r2_s;
  assign in_ready  = r1_s;
  assign out_valid = v2_r;
  assign y         = y_r;
  assign cout      = cout_r;

  // Stage-1 operand conditioning and per-group generate/propagate.
  always_comb begin
    b_eff_s = sub ? ~b : b;
    g_s     = a & b_eff_s;
    p_s     = a | b_eff_s;
    x_s     = a ^ b_eff_s;
    gg_s    = {NG{1'b0}};
    gp_s    = {NG{1'b0}};
    for (int k = 32'sd0; k < NG; k++) begin
      {gg_s[k], gp_s[k]} = grp_gp(g_s[k*BLOCK +: BLOCK], p_s[k*BLOCK +: BLOCK]);
    end
  end

  // Stage-2 carry resolution from the stage-1 registers.
  always_comb begin
    cg_s    = grp_carry(gg_r, gp_r, c0_r);
    carry_s = bit_carry(g_r, p_r, cg_s);
    sum_s   = x_r ^ carry_s;
  end

  // Stage-1 registers: advance whenever stage 1 is empty or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      g_r  <= {WIDTH{1'b0}};
      p_r  <= {WIDTH{1'b0}};
      x_r  <= {WIDTH{1'b0}};
      gg_r <= {NG{1'b0}};
      gp_r <= {NG{1'b0}};
      c0_r <= 1'b0;
    end else if (r1_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        g_r  <= g_s;
        p_r  <= p_s;
        x_r  <= x_s;
        gg_r <= gg_s;
        gp_r <= gp_s;
        c0_r <= sub ? 1'b1 : cin;
      end
    end
  end

  // Stage-2 result registers; hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r   <= 1'b0;
      y_r    <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
    end else if (r2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        y_r    <= sum_s;
        cout_r <= cg_s[NG];
      end
    end
  end

`ifdef CLA_OVF_EN
  logic ovf_r;
  assign ovf = ovf_r;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (r2_s && v1_r) begin
      ovf_r <= carry_s[WIDTH-1] ^ cg_s[NG];
    end
  end
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and randomized self-checking bench for cla_pipe_adder (WIDTH=16, BLOCK=4).
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [15:0] a, b, y;
  logic        ovf_obs;
  int          checks = 0;
  int          errors = 0;

`ifdef CLA_OVF_EN
  logic ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .cout(cout)
`ifdef CLA_OVF_EN
    , .ovf(ovf)
`endif
  );

  // Single transaction into an empty pipe; returns observations one and two cycles after accept.
  task automatic run_vec(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts,
                         output logic mid_v, output logic out_v, output logic [15:0] oy,
                         output logic oc, output logic oo);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mid_v = out_valid;
    @(posedge clk); #1;
    out_v = out_valid; oy = y; oc = cout; oo = ovf_obs;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || y !== 16'h0 || cout !== 1'b0 || ovf_obs !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b y=%h c=%b o=%b expected 0 0000 0 0", out_valid, y, cout, ovf_obs);
    end
    #15 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got v=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_vectors(input string name, input logic [15:0] ta, input logic [15:0] tb_,
                              input logic tc, input logic ts, input logic [15:0] ey,
                              input logic ec, input logic eo);
    logic mv, ov, oc, oo;
    logic [15:0] oy;
    run_vec(ta, tb_, tc, ts, mv, ov, oy, oc, oo);
    checks++;
    if (mv !== 1'b0 || ov !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: got v@1=%b v@2=%b expected 0 1", name, mv, ov);
    end
    checks++;
    if (oy !== ey || oc !== ec) begin
      errors++;
      $display("FAIL %s_result: got y=%h c=%b expected y=%h c=%b", name, oy, oc, ey, ec);
    end
`ifdef CLA_OVF_EN
    checks++;
    if (oo !== eo) begin
      errors++;
      $display("FAIL %s_ovf: got %b expected %b", name, oo, eo);
    end
`endif
  endtask

  task automatic test_carry_chain;
    test_vectors("carry_full", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_vectors("carry_cin",  16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
  endtask

  task automatic test_subtract;
    test_vectors("sub_borrow",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_vectors("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
  endtask

  task automatic test_ovf;
    test_vectors("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_vectors("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back;
    int nout;
    logic [15:0] ey;
    nout = 0;
    out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready[%0d]: got %b expected 1", c, in_ready);
        end
      end
      in_valid = (c < 8);
      a = 16'(c);
      b = 16'(16'h1000 * c);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== ((c >= 1) && (c <= 8))) begin
        errors++;
        $display("FAIL stream_valid[%0d]: got %b expected %b", c, out_valid, (c >= 1) && (c <= 8));
      end
      if (out_valid === 1'b1) begin
        ey = 16'(16'h1001 * nout);
        checks++;
        if (y !== ey) begin
          errors++;
          $display("FAIL stream_y[%0d]: got %h expected %h", nout, y, ey);
        end
        nout++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nout != 8) begin
      errors++;
      $display("FAIL stream_count: got %0d expected 8", nout);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
    a = 16'h0010; b = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h0020; b = 16'h0002;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    a = 16'h0030; b = 16'h0003;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 16'h0011) begin
        errors++;
        $display("FAIL bp_stall[%0d]: got rdy=%b v=%b y=%h expected 0 1 0011", k, in_ready, out_valid, y);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || y !== 16'h0022) begin
      errors++;
      $display("FAIL bp_second_out: got v=%b y=%h expected 1 0022", out_valid, y);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || y !== 16'h0033) begin
      errors++;
      $display("FAIL bp_third_out: got v=%b y=%h expected 1 0033", out_valid, y);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained: got v=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight;
    logic mv, ov, oc, oo;
    logic [15:0] oy;
    out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h0101; b = 16'h0101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || y !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_immediate: got v=%b y=%h expected 0 0000", out_valid, y);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale[%0d]: got v=%b expected 0", k, out_valid);
      end
      @(posedge clk); #1;
    end
    run_vec(16'h0003, 16'h0004, 1'b0, 1'b0, mv, ov, oy, oc, oo);
    checks++;
    if (mv !== 1'b0 || ov !== 1'b1 || oy !== 16'h0007) begin
      errors++;
      $display("FAIL midrst_first: got v@1=%b v@2=%b y=%h expected 0 1 0007", mv, ov, oy);
    end
  endtask

  task automatic test_random;
    logic [17:0] q[$];
    logic [17:0] exp_v;
    logic [15:0] ra, rb, ey;
    logic        rc, rs, pend, ec, eo;
    int          tot, sd, popped;
    pend = 1'b0; popped = 0; ra = 16'h0; rb = 16'h0; rc = 1'b0; rs = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        ra = 16'($urandom); rb = 16'($urandom);
        rc = 1'($urandom); rs = 1'($urandom);
        pend = 1'b1;
      end
      in_valid = pend; a = ra; b = rb; cin = rc; sub = rs;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        exp_v = (q.size() > 0) ? q.pop_front() : 18'h0;
        if (y !== exp_v[15:0] || cout !== exp_v[16]
`ifdef CLA_OVF_EN
            || ovf !== exp_v[17]
`endif
           ) begin
          errors++;
          $display("FAIL rand_out[%0d]: got y=%h c=%b o=%b expected y=%h c=%b o=%b",
                   popped, y, cout, ovf_obs, exp_v[15:0], exp_v[16], exp_v[17]);
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        if (rs) begin
          ey = ra - rb;
          ec = (ra >= rb);
          sd = int'($signed(ra)) - int'($signed(rb));
        end else begin
          tot = int'(ra) + int'(rb) + int'(rc);
          ey  = tot[15:0];
          ec  = tot[16];
          sd  = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
        end
        eo = (sd > 32767) || (sd < -32768);
        q.push_back({eo, ec, ey});
        pend = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        checks++;
        exp_v = (q.size() > 0) ? q.pop_front() : 18'h0;
        if (y !== exp_v[15:0] || cout !== exp_v[16]) begin
          errors++;
          $display("FAIL rand_drain: got y=%h c=%b expected y=%h c=%b", y, cout, exp_v[15:0], exp_v[16]);
        end
        popped++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (q.size() != 0 || popped < 100) begin
      errors++;
      $display("FAIL rand_count: got left=%0d popped=%0d expected left=0 popped>=100", q.size(), popped);
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_subtract();
`ifdef CLA_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
